// File: rtl/hack_cpu_pkg.sv
// Shared constants for the Hack CPU core: instruction field positions, jump masks
// and the ALU control bundle decoded from the comp field.
package hack_cpu_pkg;

  localparam int DATA_WIDTH = 16;
  localparam logic [14:0] SW_ADDR_DEFAULT = 15'h6000;

  localparam int BIT_CINSTR = 15;
  localparam int BIT_AMSEL  = 12;
  localparam int COMP_LSB   = 6;
  localparam int DEST_A     = 5;
  localparam int DEST_D     = 4;
  localparam int DEST_M     = 3;

  localparam logic [2:0] JMP_LT = 3'b100;
  localparam logic [2:0] JMP_EQ = 3'b010;
  localparam logic [2:0] JMP_GT = 3'b001;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  function automatic alu_ctrl_t comp_field(input logic [DATA_WIDTH-1:0] w);
    return alu_ctrl_t'(w[COMP_LSB+5:COMP_LSB]);
  endfunction

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: operand zero/invert, add or AND, optional result invert,
// plus zero and negative flags.
module hack_alu
  import hack_cpu_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] y_i,
  input  alu_ctrl_t             ctrl_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zr_o,
  output logic                  ng_o
);

  logic [DATA_WIDTH-1:0] x_z, x_n, y_z, y_n, core;

  always_comb begin
    x_z  = ctrl_i.zx ? '0 : x_i;
    x_n  = ctrl_i.nx ? ~x_z : x_z;
    y_z  = ctrl_i.zy ? '0 : y_i;
    y_n  = ctrl_i.ny ? ~y_z : y_z;
    core = ctrl_i.f ? (x_n + y_n) : (x_n & y_n);
    result_o = ctrl_i.no ? ~core : core;
    zr_o     = (result_o == '0);
    ng_o     = result_o[DATA_WIDTH-1];
  end

endmodule

// File: rtl/hack_cpu.sv
// Hack-compatible accumulator CPU with a fetch/execute pipeline. The instruction on
// `inst` is the one fetched at E; a stall freezes all state and refetches E.
module hack_cpu
  import hack_cpu_pkg::*;
#(
  parameter int          PC_WIDTH    = 10,
  parameter int          INSTR_WIDTH = 32,
  parameter logic [14:0] SW_ADDR     = SW_ADDR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             SW,
  input  logic [INSTR_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]    inst_addr,
  input  logic [DATA_WIDTH-1:0]  in_m,
  output logic [DATA_WIDTH-1:0]  out_m,
  output logic                   write_m,
  output logic                   read_m,
  input  logic                   stall,
  output logic [14:0]            data_addr
);

  logic [DATA_WIDTH-1:0] a_q, a_d, d_q, d_d;
  logic [PC_WIDTH-1:0]   f_q, f_d, e_q, e_d;
  logic                  v_q, v_d;

  logic [DATA_WIDTH-1:0] instr, m_val, y_val, alu_res;
  logic                  is_c, exec_c, sw_hit, alu_zr, alu_ng, jump_take;
  logic                  unused_inst_hi;

  assign instr          = inst[DATA_WIDTH-1:0];
  assign unused_inst_hi = ^inst[INSTR_WIDTH-1:DATA_WIDTH];
  assign is_c           = instr[BIT_CINSTR];
  assign exec_c         = v_q & is_c;
  assign sw_hit         = (a_q[14:0] == SW_ADDR);
  assign m_val          = sw_hit ? {12'b0, SW} : in_m;
  assign y_val          = instr[BIT_AMSEL] ? m_val : a_q;

  hack_alu u_alu (
    .x_i      (d_q),
    .y_i      (y_val),
    .ctrl_i   (comp_field(instr)),
    .result_o (alu_res),
    .zr_o     (alu_zr),
    .ng_o     (alu_ng)
  );

  assign jump_take = exec_c & (((instr[2:0] & JMP_LT) != '0 && alu_ng) ||
                               ((instr[2:0] & JMP_EQ) != '0 && alu_zr) ||
                               ((instr[2:0] & JMP_GT) != '0 && !alu_ng && !alu_zr));

  // All writes and the jump target see the A value from before this instruction.
  always_comb begin
    a_d = a_q;
    d_d = d_q;
    f_d = f_q;
    e_d = e_q;
    v_d = v_q;
    if (!stall) begin
      e_d = f_q;
      if (jump_take) begin
        f_d = a_q[PC_WIDTH-1:0];
        v_d = 1'b0;
      end else begin
        f_d = f_q + 1'b1;
        v_d = 1'b1;
      end
      if (v_q) begin
        if (!is_c) begin
          a_d = {1'b0, instr[14:0]};
        end else begin
          if (instr[DEST_A]) a_d = alu_res;
          if (instr[DEST_D]) d_d = alu_res;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      d_q <= '0;
      f_q <= '0;
      e_q <= '0;
      v_q <= 1'b0;
    end else begin
      a_q <= a_d;
      d_q <= d_d;
      f_q <= f_d;
      e_q <= e_d;
      v_q <= v_d;
    end
  end

  assign inst_addr = reset ? '0 : (stall ? e_q : f_q);
  assign data_addr = reset ? '0 : a_q[14:0];
  assign out_m     = alu_res;
  assign write_m   = ~reset & exec_c & instr[DEST_M];
  assign read_m    = ~reset & exec_c & instr[BIT_AMSEL] & ~sw_hit;

endmodule

// File: tb/tb_hack_cpu.sv
// Bench for hack_cpu: directed pipeline/stall/jump scenarios plus random programs
// checked against an instruction-level Hack interpreter.
module tb_hack_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  SW = 4'h0;
  logic [31:0] inst;
  logic [9:0]  inst_addr;
  logic [15:0] in_m = 16'h0;
  logic [15:0] out_m;
  logic        write_m, read_m;
  logic        stall = 1'b0;
  logic [14:0] data_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rom [1024];
  logic [15:0] mmem [int];
  logic [15:0] dmem [int];
  logic [30:0] exp_q [$];

  hack_cpu dut (
    .clk       (clk),
    .reset     (reset),
    .SW        (SW),
    .inst      (inst),
    .inst_addr (inst_addr),
    .in_m      (in_m),
    .out_m     (out_m),
    .write_m   (write_m),
    .read_m    (read_m),
    .stall     (stall),
    .data_addr (data_addr)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: registers the address, delivers the word next cycle.
  always @(posedge clk) inst <= rom[inst_addr];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = {16'($urandom()), 16'h0000};
  endtask

  task automatic put(input int addr, input logic [15:0] w);
    rom[addr] = {16'($urandom()), w};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    in_m  = 16'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [15:0] alu_ref(input logic [15:0] x, input logic [15:0] y,
                                          input logic [5:0] c);
    logic [15:0] xx, yy, r;
    xx = c[5] ? 16'h0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0 : y;
    yy = c[2] ? ~yy : yy;
    r  = c[1] ? xx + yy : xx & yy;
    return c[0] ? ~r : r;
  endfunction

  // Instruction-level interpreter: one instruction per step, no pipeline notion.
  task automatic run_model(input int n, input logic [3:0] sw);
    logic [15:0] ra, rd, m, r, w;
    int pc;
    bit take;
    ra = 0; rd = 0; pc = 0;
    mmem.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      w = rom[pc][15:0];
      if (!w[15]) begin
        ra = {1'b0, w[14:0]};
        pc = (pc + 1) % 1024;
      end else begin
        if (ra[14:0] == 15'h6000) m = {12'b0, sw};
        else if (mmem.exists(int'(ra[14:0]))) m = mmem[int'(ra[14:0])];
        else m = 16'h0;
        r = alu_ref(rd, w[12] ? m : ra, w[11:6]);
        take = (w[2] && r[15]) || (w[1] && r == 0) || (w[0] && !r[15] && r != 0);
        if (w[3]) begin
          mmem[int'(ra[14:0])] = r;
          exp_q.push_back({ra[14:0], r});
        end
        pc = take ? int'(ra[9:0]) : (pc + 1) % 1024;
        if (w[5]) ra = r;
        if (w[4]) rd = r;
      end
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [14:0] av;
    logic [2:0]  j;
    if ($urandom_range(0, 1) == 0) begin
      case ($urandom_range(0, 7))
        0:       av = 15'h6000;
        1:       av = 15'($urandom());
        default: av = 15'($urandom_range(0, 63));
      endcase
      return {1'b0, av};
    end
    j = ($urandom_range(0, 15) == 0) ? 3'($urandom()) : 3'b000;
    return {1'b1, 2'($urandom()), 1'($urandom()), 6'($urandom()), 3'($urandom()), j};
  endfunction

  task automatic test_reset();
    clear_rom();
    put(0, 16'h0005); put(1, 16'hEC10); put(2, 16'h0064); put(3, 16'hE308);
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++; if (write_m !== 1'b0) begin n_fail++; $display("FAIL rst_write_m: got %b expected 0", write_m); end
      n_checks++; if (read_m !== 1'b0) begin n_fail++; $display("FAIL rst_read_m: got %b expected 0", read_m); end
      n_checks++; if (inst_addr !== 10'd0) begin n_fail++; $display("FAIL rst_inst_addr: got %0d expected 0", inst_addr); end
      n_checks++; if (data_addr !== 15'd0) begin n_fail++; $display("FAIL rst_data_addr: got %h expected 0", data_addr); end
    end
    reset = 1'b0;
    stall = 1'b0;
    #1;
    n_checks++; if (inst_addr !== 10'd0) begin n_fail++; $display("FAIL first_addr0: got %0d expected 0", inst_addr); end
    tick();
    n_checks++; if (inst_addr !== 10'd1) begin n_fail++; $display("FAIL first_addr1: got %0d expected 1", inst_addr); end
    tick();
    n_checks++; if (inst_addr !== 10'd2) begin n_fail++; $display("FAIL first_addr2: got %0d expected 2", inst_addr); end
    tick(); tick();
    n_checks++; if ({write_m, data_addr, out_m} !== {1'b1, 15'd100, 16'd5})
      begin n_fail++; $display("FAIL first_d_eq_5: got wr=%b addr=%h data=%h expected wr=1 addr=0064 data=0005", write_m, data_addr, out_m); end
  endtask

  task automatic test_mem_write();
    clear_rom();
    put(0, 16'h1234); put(1, 16'hEC10); put(2, 16'h0007); put(3, 16'hE308);
    do_reset();
    tick(); tick(); tick();
    n_checks++; if (write_m !== 1'b0) begin n_fail++; $display("FAIL wr_before: got %b expected 0", write_m); end
    tick();
    n_checks++; if ({write_m, data_addr, out_m} !== {1'b1, 15'd7, 16'h1234})
      begin n_fail++; $display("FAIL wr_txn: got wr=%b addr=%h data=%h expected wr=1 addr=0007 data=1234", write_m, data_addr, out_m); end
    tick();
    n_checks++; if (write_m !== 1'b0) begin n_fail++; $display("FAIL wr_after: got %b expected 0", write_m); end
  endtask

  task automatic test_stall_read();
    clear_rom();
    put(0, 16'h0003); put(1, 16'hFDD0); put(2, 16'h0032); put(3, 16'hE308);
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = (i < 2);
      in_m  = (i < 2) ? 16'hDEAD : 16'h00FF;
      #1;
      n_checks++; if (read_m !== 1'b1) begin n_fail++; $display("FAIL stall_read_m[%0d]: got %b expected 1", i, read_m); end
      n_checks++; if (inst_addr !== ((i < 2) ? 10'd1 : 10'd2))
        begin n_fail++; $display("FAIL stall_inst_addr[%0d]: got %0d expected %0d", i, inst_addr, (i < 2) ? 1 : 2); end
    end
    tick();
    n_checks++; if (read_m !== 1'b0) begin n_fail++; $display("FAIL stall_read_done: got %b expected 0", read_m); end
    tick();
    n_checks++; if ({write_m, data_addr, out_m} !== {1'b1, 15'd50, 16'h0100})
      begin n_fail++; $display("FAIL stall_d_result: got wr=%b addr=%h data=%h expected wr=1 addr=0032 data=0100", write_m, data_addr, out_m); end
  endtask

  task automatic test_jump();
    clear_rom();
    put(0, 16'h0014); put(1, 16'hE302); put(2, 16'hE308); put(20, 16'h004D); put(21, 16'hE308);
    do_reset();
    tick(); tick(); tick();
    n_checks++; if (inst_addr !== 10'd20) begin n_fail++; $display("FAIL jeq_target: got %0d expected 20", inst_addr); end
    n_checks++; if (write_m !== 1'b0) begin n_fail++; $display("FAIL jeq_bubble_write: got %b expected 0", write_m); end
    tick();
    n_checks++; if ({inst_addr, data_addr} !== {10'd21, 15'd20})
      begin n_fail++; $display("FAIL jeq_exec20: got ia=%0d da=%h expected ia=21 da=0014", inst_addr, data_addr); end
    tick();
    n_checks++; if ({write_m, data_addr, out_m} !== {1'b1, 15'h4D, 16'h0})
      begin n_fail++; $display("FAIL jeq_exec21: got wr=%b addr=%h data=%h expected wr=1 addr=004d data=0000", write_m, data_addr, out_m); end

    clear_rom();
    put(0, 16'h03FD); put(1, 16'hEA87); put(1021, 16'hEFD0); put(1022, 16'h0005); put(1023, 16'hE302);
    do_reset();
    tick(); tick(); tick();
    n_checks++; if (inst_addr !== 10'd1021) begin n_fail++; $display("FAIL jmp_target: got %0d expected 1021", inst_addr); end
    tick(); tick(); tick();
    n_checks++; if (inst_addr !== 10'd0) begin n_fail++; $display("FAIL pc_wrap: got %0d expected 0", inst_addr); end
    tick();
    n_checks++; if ({inst_addr, data_addr} !== {10'd1, 15'd5})
      begin n_fail++; $display("FAIL jeq_fallthru: got ia=%0d da=%h expected ia=1 da=0005", inst_addr, data_addr); end
    tick();
    n_checks++; if (data_addr !== 15'd1021) begin n_fail++; $display("FAIL no_bubble: got %h expected 03fd", data_addr); end
  endtask

  task automatic test_switch();
    clear_rom();
    SW = 4'hA;
    put(0, 16'h6000); put(1, 16'hFC10); put(2, 16'h0009); put(3, 16'hE308);
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = (i < 2);
      in_m  = (i < 2) ? 16'hBEEF : 16'h5555;
      #1;
      n_checks++; if (read_m !== 1'b0) begin n_fail++; $display("FAIL sw_read_m[%0d]: got %b expected 0", i, read_m); end
    end
    tick(); tick();
    n_checks++; if ({write_m, data_addr, out_m} !== {1'b1, 15'd9, 16'h000A})
      begin n_fail++; $display("FAIL sw_value: got wr=%b addr=%h data=%h expected wr=1 addr=0009 data=000a", write_m, data_addr, out_m); end
  endtask

  task automatic test_alu_sweep();
    logic [5:0]  codes [18];
    logic [15:0] expv  [18];
    logic [15:0] d, a;
    d = 16'h00F0;
    a = 16'h0F0F;
    codes = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
              6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
              6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};
    expv  = '{16'h0, 16'h1, 16'hFFFF, d, a, ~d, ~a, -d, -a, d + 1, a + 1, d - 1,
              a - 1, d + a, d - a, a - d, d & a, d | a};
    clear_rom();
    put(0, 16'h00F0); put(1, 16'hEC10); put(2, 16'h0F0F);
    for (int i = 0; i < 18; i++) put(3 + i, 16'hE008 | (16'(codes[i]) << 6));
    do_reset();
    tick(); tick(); tick();
    for (int i = 0; i < 18; i++) begin
      tick();
      n_checks++; if ({write_m, data_addr, out_m} !== {1'b1, 15'h0F0F, expv[i]})
        begin n_fail++; $display("FAIL alu_comp_%b: got wr=%b addr=%h data=%h expected wr=1 addr=0f0f data=%h", codes[i], write_m, data_addr, out_m, expv[i]); end
    end
  endtask

  task automatic test_random(input int rounds);
    logic [30:0] got, e;
    logic [14:0] pend_addr;
    logic [15:0] pend_data;
    bit have_pend;
    int n_wr;
    for (int r = 0; r < rounds; r++) begin
      SW = 4'($urandom());
      for (int i = 0; i < 1024; i++) rom[i] = {16'($urandom()), rand_instr()};
      run_model(4000, SW);
      dmem.delete();
      have_pend = 0;
      n_wr = 0;
      do_reset();
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        if (have_pend) begin
          dmem[int'(pend_addr)] = pend_data;
          have_pend = 0;
        end
        stall = ($urandom_range(0, 3) == 0);
        if (stall) in_m = 16'($urandom());
        else in_m = dmem.exists(int'(data_addr)) ? dmem[int'(data_addr)] : 16'h0;
        #1;
        if (write_m && !stall) begin
          got = {data_addr, out_m};
          n_wr++;
          have_pend = 1;
          pend_addr = data_addr;
          pend_data = out_m;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL rand_extra_write: got %h expected no write", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin n_fail++; $display("FAIL rand_write[%0d]: got %h expected %h", n_wr, got, e); end
          end
        end
      end
      stall = 1'b0;
      n_checks++; if (n_wr == 0) begin n_fail++; $display("FAIL rand_activity: got 0 writes expected at least 1"); end
    end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_mem_write();
    test_stall_read();
    test_jump();
    test_switch();
    test_alu_sweep();
    test_random(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
